// File: rtl/pipe_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_pkg
//  Description : Shared encodings for the pipeline hazard controller:
//                next-PC ops, writeback selects, forwarding selects, FSM state.
//  Revision    : 1.0  initial release
// ============================================================================
package pipe_pkg;

  // Next-PC operation carried by the instruction in EX
  localparam logic [1:0] NPC_PC4  = 2'b00;
  localparam logic [1:0] NPC_BR   = 2'b01;
  localparam logic [1:0] NPC_JAL  = 2'b10;
  localparam logic [1:0] NPC_JALR = 2'b11;

  // Register-file writeback source; WSEL_RAM identifies a load
  localparam logic [1:0] WSEL_ALU = 2'b00;
  localparam logic [1:0] WSEL_RAM = 2'b01;
  localparam logic [1:0] WSEL_PC4 = 2'b10;
  localparam logic [1:0] WSEL_IMM = 2'b11;

  // EX operand source selects
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_MEM = 2'b01;
  localparam logic [1:0] FWD_WB  = 2'b10;

  // Memory-wait monitor state
  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  // True when the EX instruction changes control flow
  function automatic logic is_redirect(input logic [1:0] npc_op,
                                       input logic       br_taken);
    logic r;
    r = 1'b0;
    case (npc_op)
      NPC_BR:   r = br_taken;
      NPC_JAL:  r = 1'b1;
      NPC_JALR: r = 1'b1;
      default:  r = 1'b0;
    endcase
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/pipe_hazard_ctrl_fwd_sel.sv
`default_nettype none
// ============================================================================
//  Module      : fwd_sel
//  Description : Forwarding source select for one EX operand. The younger
//                result in EX/MEM has priority over the one in MEM/WB; x0 is
//                never forwarded.
//  Revision    : 1.0  initial release
// ============================================================================
module fwd_sel (
  input  logic [4:0] ex_rs,
  input  logic [4:0] mem_rd,
  input  logic       mem_rf_we,
  input  logic [4:0] wb_rd,
  input  logic       wb_rf_we,
  output logic [1:0] sel
);
  import pipe_pkg::*;

  // Priority match: MEM first, then WB, else register file
  always_comb begin
    sel = FWD_RF;
    if (mem_rf_we && (mem_rd != 5'd0) && (mem_rd == ex_rs)) begin
      sel = FWD_MEM;
    end else if (wb_rf_we && (wb_rd != 5'd0) && (wb_rd == ex_rs)) begin
      sel = FWD_WB;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipe_hazard_ctrl
//  Description : Stall/flush generation for the five pipeline registers,
//                EX operand forwarding selects, data-memory wait timeout
//                monitor and saturating stall/flush performance counters.
//  Revision    : 1.0  initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  id_rs1,
  input  logic [4:0]  id_rs2,
  input  logic        id_rs1_used,
  input  logic        id_rs2_used,
  input  logic [4:0]  ex_rs1,
  input  logic [4:0]  ex_rs2,
  input  logic [4:0]  ex_rd,
  input  logic        ex_rf_we,
  input  logic [1:0]  ex_rf_wsel,
  input  logic [1:0]  ex_npc_op,
  input  logic        ex_br_taken,
  input  logic [4:0]  mem_rd,
  input  logic        mem_rf_we,
  input  logic [4:0]  wb_rd,
  input  logic        wb_rf_we,
  input  logic        dmem_req,
  input  logic        dmem_ack,
  output logic        pc_stall,
  output logic        if_id_stall,
  output logic        if_id_flush,
  output logic        id_ex_stall,
  output logic        id_ex_flush,
  output logic        ex_mem_stall,
  output logic        mem_wb_flush,
  output logic [1:0]  fwd_rs1_sel,
  output logic [1:0]  fwd_rs2_sel,
  output logic        err_timeout,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);
  import pipe_pkg::*;

  localparam int         CW        = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] C_TIMEOUT = CW'(TIMEOUT);
  localparam logic [0:0] S_RUN     = ST_RUN;
  localparam logic [0:0] S_WAIT    = ST_WAIT;

  logic          mem_wait;
  logic          redirect;
  logic          load_use;
  logic          id_hit;
  logic [1:0]    fwd1_raw;
  logic [1:0]    fwd2_raw;

  logic          sup_q,   sup_d;
  logic [0:0]    state_q, state_d;
  logic [CW-1:0] wcnt_q,  wcnt_d;
  logic          err_q,   err_d;
  logic [31:0]   stall_cnt_q, stall_cnt_d;
  logic [31:0]   flush_cnt_q, flush_cnt_d;

  // Hazard classification in priority order: mem_wait > redirect > load_use.
  // A redirect during mem_wait is simply held by the EX stall until the wait ends.
  always_comb begin
    mem_wait = dmem_req & ~dmem_ack;
    redirect = is_redirect(ex_npc_op, ex_br_taken) & ~mem_wait;
    id_hit   = (id_rs1_used && (id_rs1 == ex_rd)) ||
               (id_rs2_used && (id_rs2 == ex_rd));
    // The suppress bit masks load_use while ID holds a just-flushed bubble
    load_use = (ex_rf_wsel == WSEL_RAM) && ex_rf_we && (ex_rd != 5'd0) &&
               id_hit && !mem_wait && !redirect && !sup_q;
  end

  // Stall/flush drive; everything is held at 0 while in reset
  always_comb begin
    pc_stall     = 1'b0;
    if_id_stall  = 1'b0;
    if_id_flush  = 1'b0;
    id_ex_stall  = 1'b0;
    id_ex_flush  = 1'b0;
    ex_mem_stall = 1'b0;
    mem_wb_flush = 1'b0;
    if (!rst) begin
      if (mem_wait) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_stall  = 1'b1;
        ex_mem_stall = 1'b1;
        mem_wb_flush = 1'b1;
      end else if (redirect) begin
        if_id_flush  = 1'b1;
        id_ex_flush  = 1'b1;
      end else if (load_use) begin
        pc_stall     = 1'b1;
        if_id_stall  = 1'b1;
        id_ex_flush  = 1'b1;
      end
    end
  end

  fwd_sel u_fwd_rs1 (
    .ex_rs     (ex_rs1),
    .mem_rd    (mem_rd),
    .mem_rf_we (mem_rf_we),
    .wb_rd     (wb_rd),
    .wb_rf_we  (wb_rf_we),
    .sel       (fwd1_raw)
  );

  fwd_sel u_fwd_rs2 (
    .ex_rs     (ex_rs2),
    .mem_rd    (mem_rd),
    .mem_rf_we (mem_rf_we),
    .wb_rd     (wb_rd),
    .wb_rf_we  (wb_rf_we),
    .sel       (fwd2_raw)
  );

  // Forward selects, forced to register-file source during reset
  always_comb begin
    fwd_rs1_sel = rst ? FWD_RF : fwd1_raw;
    fwd_rs2_sel = rst ? FWD_RF : fwd2_raw;
  end

  // Next-state for suppress bit and saturating performance counters
  always_comb begin
    sup_d       = redirect;
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (pc_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
    if ((if_id_flush || id_ex_flush) && (flush_cnt_q != 32'hFFFF_FFFF)) begin
      flush_cnt_d = flush_cnt_q + 32'd1;
    end
  end

  // Memory-wait monitor: counts cycles spent in WAIT and latches a timeout
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    err_d   = err_q;
    case (state_q)
      S_RUN: begin
        if (mem_wait) begin
          state_d = S_WAIT;
          wcnt_d  = '0;
        end
      end
      S_WAIT: begin
        if (wcnt_q != C_TIMEOUT) begin
          wcnt_d = wcnt_q + CW'(1);
        end
        if (wcnt_d == C_TIMEOUT) begin
          err_d = 1'b1;
        end
        if (dmem_ack || !dmem_req) begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_RUN;
        wcnt_d  = '0;
      end
    endcase
  end

  // State registers with asynchronous active-high reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sup_q       <= 1'b0;
      state_q     <= S_RUN;
      wcnt_q      <= '0;
      err_q       <= 1'b0;
      stall_cnt_q <= 32'd0;
      flush_cnt_q <= 32'd0;
    end else begin
      sup_q       <= sup_d;
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      err_q       <= err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign err_timeout = err_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipe_hazard_ctrl
//  Description : Directed self-checking bench for pipe_hazard_ctrl.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
  logic        id_rs1_used, id_rs2_used, ex_rf_we, ex_br_taken;
  logic [1:0]  ex_rf_wsel, ex_npc_op;
  logic        mem_rf_we, wb_rf_we, dmem_req, dmem_ack;
  logic        pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush;
  logic        ex_mem_stall, mem_wb_flush, err_timeout;
  logic [1:0]  fwd_rs1_sel, fwd_rs2_sel;
  logic [31:0] stall_cnt, flush_cnt;
  logic [6:0]  ctl;

  int n_chk  = 0;
  int n_fail = 0;

  pipe_hazard_ctrl #(.TIMEOUT(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
    .id_rs1_used  (id_rs1_used),
    .id_rs2_used  (id_rs2_used),
    .ex_rs1       (ex_rs1),
    .ex_rs2       (ex_rs2),
    .ex_rd        (ex_rd),
    .ex_rf_we     (ex_rf_we),
    .ex_rf_wsel   (ex_rf_wsel),
    .ex_npc_op    (ex_npc_op),
    .ex_br_taken  (ex_br_taken),
    .mem_rd       (mem_rd),
    .mem_rf_we    (mem_rf_we),
    .wb_rd        (wb_rd),
    .wb_rf_we     (wb_rf_we),
    .dmem_req     (dmem_req),
    .dmem_ack     (dmem_ack),
    .pc_stall     (pc_stall),
    .if_id_stall  (if_id_stall),
    .if_id_flush  (if_id_flush),
    .id_ex_stall  (id_ex_stall),
    .id_ex_flush  (id_ex_flush),
    .ex_mem_stall (ex_mem_stall),
    .mem_wb_flush (mem_wb_flush),
    .fwd_rs1_sel  (fwd_rs1_sel),
    .fwd_rs2_sel  (fwd_rs2_sel),
    .err_timeout  (err_timeout),
    .stall_cnt    (stall_cnt),
    .flush_cnt    (flush_cnt)
  );

  // {pc_stall, if_id_stall, if_id_flush, id_ex_stall, id_ex_flush, ex_mem_stall, mem_wb_flush}
  assign ctl = {pc_stall, if_id_stall, if_id_flush, id_ex_stall,
                id_ex_flush, ex_mem_stall, mem_wb_flush};

  localparam logic [6:0] CTL_NONE  = 7'b0000000;
  localparam logic [6:0] CTL_LU    = 7'b1100100;
  localparam logic [6:0] CTL_REDIR = 7'b0010100;
  localparam logic [6:0] CTL_WAIT  = 7'b1101011;

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    id_rs1 = 5'd0; id_rs2 = 5'd0; id_rs1_used = 1'b0; id_rs2_used = 1'b0;
    ex_rs1 = 5'd0; ex_rs2 = 5'd0; ex_rd = 5'd0; ex_rf_we = 1'b0;
    ex_rf_wsel = 2'b00; ex_npc_op = 2'b00; ex_br_taken = 1'b0;
    mem_rd = 5'd0; mem_rf_we = 1'b0; wb_rd = 5'd0; wb_rf_we = 1'b0;
    dmem_req = 1'b0; dmem_ack = 1'b0;
  endtask

  task automatic set_load_use(input logic [4:0] rd);
    ex_rf_wsel = 2'b01; ex_rf_we = 1'b1; ex_rd = rd;
  endtask

  initial begin
    // ---------------- reset ----------------
    rst = 1'b1;
    idle();
    dmem_req = 1'b1;
    mem_rd = 5'd3; mem_rf_we = 1'b1; ex_rs1 = 5'd3;
    #2;
    chk("rst_ctl",   {25'd0, ctl}, {25'd0, CTL_NONE});
    chk("rst_fwd1",  {30'd0, fwd_rs1_sel}, 32'd0);
    chk("rst_stall", stall_cnt, 32'd0);
    chk("rst_flush", flush_cnt, 32'd0);
    chk("rst_err",   {31'd0, err_timeout}, 32'd0);
    tick();
    tick();
    idle();
    rst = 1'b0;
    tick();

    // ---------------- load-use ----------------
    set_load_use(5'd5); id_rs1 = 5'd5; id_rs1_used = 1'b0;
    #1 chk("lu_unused", {25'd0, ctl}, {25'd0, CTL_NONE});
    id_rs1 = 5'd0; id_rs1_used = 1'b1; ex_rd = 5'd0;
    #1 chk("lu_rd0", {25'd0, ctl}, {25'd0, CTL_NONE});
    ex_rd = 5'd5; id_rs1 = 5'd5;
    #1 chk("lu_stall", {25'd0, ctl}, {25'd0, CTL_LU});
    tick();
    chk("lu_stall_cnt", stall_cnt, 32'd1);
    chk("lu_flush_cnt", flush_cnt, 32'd1);
    idle();
    #1 chk("lu_once", {25'd0, ctl}, {25'd0, CTL_NONE});
    tick();

    // ---------------- redirect vs load-use ----------------
    ex_npc_op = 2'b01; ex_br_taken = 1'b0;
    #1 chk("br_not_taken", {25'd0, ctl}, {25'd0, CTL_NONE});
    ex_br_taken = 1'b1;
    #1 chk("br_taken", {25'd0, ctl}, {25'd0, CTL_REDIR});
    ex_br_taken = 1'b0; ex_npc_op = 2'b10;
    set_load_use(5'd9); id_rs2 = 5'd9; id_rs2_used = 1'b1;
    #1 chk("jal_lu", {25'd0, ctl}, {25'd0, CTL_REDIR});
    tick();
    ex_npc_op = 2'b00;
    #1 chk("lu_suppressed", {25'd0, ctl}, {25'd0, CTL_NONE});
    tick();
    chk("jal_flush_cnt", flush_cnt, 32'd2);
    chk("jal_stall_cnt", stall_cnt, 32'd1);
    #1 chk("lu_after_sup", {25'd0, ctl}, {25'd0, CTL_LU});
    tick();
    chk("lu2_stall_cnt", stall_cnt, 32'd2);
    chk("lu2_flush_cnt", flush_cnt, 32'd3);
    idle();

    // ---------------- memory wait with held redirect ----------------
    dmem_req = 1'b1; dmem_ack = 1'b0; ex_npc_op = 2'b10;
    #1 chk("wait_c0", {25'd0, ctl}, {25'd0, CTL_WAIT});
    tick();
    chk("wait_state", {31'd0, dut.state_q}, 32'd1);
    chk("wait_c1", {25'd0, ctl}, {25'd0, CTL_WAIT});
    tick();
    tick();
    dmem_ack = 1'b1;
    #1 chk("redir_after_wait", {25'd0, ctl}, {25'd0, CTL_REDIR});
    chk("wait_stall_cnt", stall_cnt, 32'd5);
    tick();
    chk("ack_state", {31'd0, dut.state_q}, 32'd0);
    chk("ack_flush_cnt", flush_cnt, 32'd4);
    chk("ack_err", {31'd0, err_timeout}, 32'd0);
    idle();
    set_load_use(5'd4); id_rs1 = 5'd4; id_rs1_used = 1'b1;
    #1 chk("sup_after_wait", {25'd0, ctl}, {25'd0, CTL_NONE});
    tick();
    idle();
    dmem_req = 1'b1; dmem_ack = 1'b1;
    #1 chk("req_ack_same", {25'd0, ctl}, {25'd0, CTL_NONE});
    tick();
    chk("req_ack_state", {31'd0, dut.state_q}, 32'd0);
    chk("req_ack_stall", stall_cnt, 32'd5);
    idle();

    // ---------------- forwarding ----------------
    ex_rs2 = 5'd7; mem_rd = 5'd7; wb_rd = 5'd7; mem_rf_we = 1'b1; wb_rf_we = 1'b1;
    #1 chk("fwd_mem", {30'd0, fwd_rs2_sel}, 32'd1);
    mem_rf_we = 1'b0;
    #1 chk("fwd_wb", {30'd0, fwd_rs2_sel}, 32'd2);
    ex_rs2 = 5'd0; mem_rd = 5'd0; wb_rd = 5'd0; mem_rf_we = 1'b1;
    #1 chk("fwd_rd0", {30'd0, fwd_rs2_sel}, 32'd0);
    ex_rs1 = 5'd3; wb_rd = 5'd3; mem_rd = 5'd8;
    #1 chk("fwd_rs1_wb", {30'd0, fwd_rs1_sel}, 32'd2);
    idle();
    tick();

    // ---------------- timeout ----------------
    dmem_req = 1'b1; dmem_ack = 1'b0;
    tick();           // enter WAIT
    tick();           // WAIT cycle 1
    tick();           // WAIT cycle 2
    tick();           // WAIT cycle 3
    chk("to_before", {31'd0, err_timeout}, 32'd0);
    tick();           // WAIT cycle 4
    chk("to_set", {31'd0, err_timeout}, 32'd1);
    chk("to_stall_cnt", stall_cnt, 32'd10);
    dmem_ack = 1'b1;
    tick();
    chk("to_sticky", {31'd0, err_timeout}, 32'd1);
    chk("to_state", {31'd0, dut.state_q}, 32'd0);
    chk("to_stall_hold", stall_cnt, 32'd10);
    idle();

    // ---------------- reset during WAIT ----------------
    dmem_req = 1'b1; dmem_ack = 1'b0;
    mem_rd = 5'd7; mem_rf_we = 1'b1; ex_rs1 = 5'd7;
    tick();
    tick();
    chk("pre_rst_state", {31'd0, dut.state_q}, 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mrst_ctl",   {25'd0, ctl}, {25'd0, CTL_NONE});
    chk("mrst_fwd1",  {30'd0, fwd_rs1_sel}, 32'd0);
    chk("mrst_stall", stall_cnt, 32'd0);
    chk("mrst_flush", flush_cnt, 32'd0);
    chk("mrst_err",   {31'd0, err_timeout}, 32'd0);
    chk("mrst_state", {31'd0, dut.state_q}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
